dsm_capture_buffer: RTL and testbench

//   Multi-channel delta-sigma sample capture/playback buffer in one clock domain.

---
 rtl/dsm_buffer_pkg.sv | 21 ++
 rtl/dsm_buffer_ram.sv | 27 ++
 rtl/dsm_capture_buffer.sv | 166 ++++++++++++++++
 tb/tb_dsm_capture_buffer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsm_buffer_pkg.sv
// Shared definitions for the delta-sigma capture/playback buffer:
// write-side state encodings and a constant-safe clog2 helper.
package dsm_buffer_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_FULL = 2'd2
  } wr_state_e;

  // Address width for a given depth, never less than one bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dsm_buffer_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port.
// No reset on storage or read register.
module dsm_buffer_ram #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dsm_capture_buffer.sv
// Multi-channel delta-sigma capture/playback buffer (single clock domain).
// Optional feature macro: DSM_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module dsm_capture_buffer
  import dsm_buffer_pkg::*;
#(
  parameter int  MOD_BITS = 4,
  parameter int  SAMPLES  = 16,
  parameter int  CHANNELS = 1,
  localparam int PTR_W    = clog2_min1(SAMPLES),
  localparam int W        = CHANNELS * MOD_BITS
) (
  input  logic           internal_clk,
  input  logic           internal_rst,
  input  logic           cap_start,
  input  logic           cap_valid,
  input  logic [W-1:0]   cap_data,
  input  logic           play_en,
  input  logic           play_loop,
  input  logic           play_ready,
  output logic [W-1:0]   internal_bit,
  output logic           internal_valid,
  output logic [PTR_W:0] fill_level,
  output logic [1:0]     wr_state,
  output logic           overflow,
  output logic           play_done
`ifdef DSM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]    underrun_cnt
`endif
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SAMPLES - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(SAMPLES);

  wr_state_e        wr_state_q, wr_state_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             loaded_q, loaded_d;
  logic             wr_en;
  logic             transfer;
  logic             load;
  logic [W-1:0]     ram_rd_data;

  // Write side: cap_start restarts from any state and drops a same-cycle sample.
  always_comb begin
    wr_state_d = wr_state_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (cap_start) begin
      wr_state_d = W_FILL;
      fill_d     = '0;
      overflow_d = 1'b0;
    end else begin
      case (wr_state_q)
        W_FILL: begin
          if (cap_valid) begin
            wr_en  = 1'b1;
            fill_d = fill_q + CNT_W'(1);
            if (fill_q == LAST_IDX) wr_state_d = W_FULL;
          end
        end
        W_FULL: begin
          if (cap_valid) overflow_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read side: rd_ptr < fill_q keeps reads strictly behind the write address.
  assign transfer = valid_q && play_ready;
  assign load     = (!valid_q || transfer) && play_en && !done_q && !cap_start
                    && (rd_ptr_q < fill_q);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    done_d   = done_q;
    loaded_d = loaded_q | load;
    if (cap_start || !play_en) begin
      rd_ptr_d = '0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      if (rd_ptr_q == LAST_IDX) begin
        rd_ptr_d = (play_loop && wr_state_q == W_FULL) ? '0 : DEPTH_CNT;
      end else begin
        rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end
    end else if (transfer) begin
      valid_d = 1'b0;
      // A parked pointer means the sample just taken was the last one.
      if (rd_ptr_q == DEPTH_CNT) done_d = 1'b1;
    end
  end

  always_ff @(posedge internal_clk or posedge internal_rst) begin
    if (internal_rst) begin
      wr_state_q <= W_IDLE;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      loaded_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      loaded_q   <= loaded_d;
    end
  end

  // The RAM read register is the output register; masked until first load so reset reads 0.
  dsm_buffer_ram #(
    .WIDTH (W),
    .DEPTH (SAMPLES),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk    (internal_clk),
    .wr_en  (wr_en),
    .wr_addr(fill_q[PTR_W-1:0]),
    .wr_data(cap_data),
    .rd_en  (load),
    .rd_addr(rd_ptr_q[PTR_W-1:0]),
    .rd_data(ram_rd_data)
  );

  assign internal_bit   = loaded_q ? ram_rd_data : '0;
  assign internal_valid = valid_q;
  assign fill_level     = fill_q;
  assign wr_state       = wr_state_q;
  assign overflow       = overflow_q;
  assign play_done      = done_q;

`ifdef DSM_UNDERRUN_CNT_EN
  logic [15:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (cap_start) begin
      underrun_d = '0;
    end else if (play_en && !done_q && !valid_q && wr_state_q != W_IDLE
                 && underrun_q != 16'hFFFF) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  always_ff @(posedge internal_clk or posedge internal_rst) begin
    if (internal_rst) underrun_q <= '0;
    else              underrun_q <= underrun_d;
  end

  assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_dsm_capture_buffer.sv
// Self-checking bench for dsm_capture_buffer (CHANNELS=2, MOD_BITS=4, SAMPLES=16):
// write-FSM vector table, then scoreboard-driven playback sequences.
module tb_dsm_capture_buffer;

  logic       clk;
  logic       rst;
  logic       cap_start;
  logic       cap_valid;
  logic [7:0] cap_data;
  logic       play_en;
  logic       play_loop;
  logic       play_ready;
  logic [7:0] internal_bit;
  logic       internal_valid;
  logic [4:0] fill_level;
  logic [1:0] wr_state;
  logic       overflow;
  logic       play_done;
`ifdef DSM_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       sb_en = 1'b0;
  logic       stall_q = 1'b0;
  logic [7:0] held_bit = '0;

  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic [4:0] exp_fill;
    logic [1:0] exp_state;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[22];

  dsm_capture_buffer #(
    .MOD_BITS(4),
    .SAMPLES (16),
    .CHANNELS(2)
  ) dut (
    .internal_clk  (clk),
    .internal_rst  (rst),
    .cap_start     (cap_start),
    .cap_valid     (cap_valid),
    .cap_data      (cap_data),
    .play_en       (play_en),
    .play_loop     (play_loop),
    .play_ready    (play_ready),
    .internal_bit  (internal_bit),
    .internal_valid(internal_valid),
    .fill_level    (fill_level),
    .wr_state      (wr_state),
    .overflow      (overflow),
    .play_done     (play_done)
`ifdef DSM_UNDERRUN_CNT_EN
    ,
    .underrun_cnt  (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [7:0] base, input bit push);
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cap_valid = 1'b1;
      cap_data  = base + 8'(k);
      if (push) exp_q.push_back(base + 8'(k));
      tick();
    end
    cap_valid = 1'b0;
  endtask

  // Consumer side: compare every accepted sample, and check held data while stalled.
  always @(negedge clk) begin
    if (sb_en) begin
      if (stall_q && internal_valid) check("hold_stable", 32'(internal_bit), 32'(held_bit));
      if (internal_valid && play_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_sample: got %0h expected none", internal_bit);
        end else begin
          check("sample", 32'(internal_bit), 32'(exp_q.pop_front()));
        end
      end
      stall_q  = internal_valid && !play_ready;
      held_bit = internal_bit;
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 8'hEE, 5'd0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 5'd0, 2'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'hDD, 5'd0, 2'd1, 1'b0};
    for (int i = 3; i <= 18; i++)
      vecs[i] = '{1'b0, 1'b1, 8'(i), 5'(i - 2), (i == 18) ? 2'd2 : 2'd1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 8'hAA, 5'd16, 2'd2, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 8'h00, 5'd16, 2'd2, 1'b1};
    vecs[21] = '{1'b1, 1'b0, 8'h00, 5'd0, 2'd1, 1'b0};

    rst = 1'b1; cap_start = 1'b0; cap_valid = 1'b0; cap_data = '0;
    play_en = 1'b0; play_loop = 1'b0; play_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_bit", 32'(internal_bit), 32'h0);
    check("rst_valid", 32'(internal_valid), 32'h0);
    check("rst_fill", 32'(fill_level), 32'h0);
    check("rst_state", 32'(wr_state), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_done", 32'(play_done), 32'h0);

    // Write FSM table
    for (int i = 0; i < 22; i++) begin
      cap_start = vecs[i].start;
      cap_valid = vecs[i].valid;
      cap_data  = vecs[i].data;
      tick();
      cap_start = 1'b0;
      cap_valid = 1'b0;
      check("vec_fill", 32'(fill_level), 32'(vecs[i].exp_fill));
      check("vec_state", 32'(wr_state), 32'(vecs[i].exp_state));
      check("vec_ovf", 32'(overflow), 32'(vecs[i].exp_ovf));
      check("vec_valid", 32'(internal_valid), 32'h0);
    end

    // One-shot playback; a 17th word in W_FULL must not disturb RAM
    sb_en = 1'b1;
    capture(8'h00, 1'b1);
    cap_valid = 1'b1; cap_data = 8'hAA;
    tick();
    cap_valid = 1'b0;
    check("ovf_set", 32'(overflow), 32'h1);
    check("ovf_fill", 32'(fill_level), 32'd16);
    play_loop = 1'b0; play_ready = 1'b1; play_en = 1'b1;
    repeat (17) tick();
    check("oneshot_drained", 32'(exp_q.size()), 32'h0);
    check("oneshot_done", 32'(play_done), 32'h1);
    check("oneshot_valid", 32'(internal_valid), 32'h0);
    tick();
    check("oneshot_done_hold", 32'(play_done), 32'h1);

    // Looping playback wraps 0x0F -> 0x00 without a bubble
    play_en = 1'b0;
    tick();
    capture(8'h00, 1'b1);
    check("restart_ovf_clr", 32'(overflow), 32'h0);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(k));
    play_loop = 1'b1; play_en = 1'b1;
    for (int c = 0; c < 37; c++) begin
      tick();
      check("loop_not_done", 32'(play_done), 32'h0);
    end
    sb_en = 1'b0;
    play_en = 1'b0;
    check("loop_drained", 32'(exp_q.size()), 32'h0);
    tick();

    // Playback trailing a slow capture: one word every 3 cycles
    sb_en = 1'b1;
    play_loop = 1'b0;
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    play_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cap_valid = 1'b1;
      cap_data  = 8'h30 + 8'(k);
      exp_q.push_back(8'h30 + 8'(k));
      tick();
      cap_valid = 1'b0;
      tick();
      check("trail_load", 32'(internal_valid), 32'h1);
      tick();
      check("trail_gap", 32'(internal_valid), 32'h0);
    end
    check("trail_drained", 32'(exp_q.size()), 32'h0);
    check("trail_done", 32'(play_done), 32'h1);
`ifdef DSM_UNDERRUN_CNT_EN
    check("underrun_cnt", 32'(underrun_cnt), 32'd32);
`endif

    // Back-pressure with play_ready pattern 1,0,0,1
    play_en = 1'b0;
    tick();
    capture(8'h50, 1'b1);
    play_en = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      play_ready = (c % 4 == 1 || c % 4 == 2) ? 1'b0 : 1'b1;
      tick();
    end
    play_ready = 1'b1;
    check("bp_drained", 32'(exp_q.size()), 32'h0);
    tick();
    tick();
    check("bp_done", 32'(play_done), 32'h1);

    // Asynchronous reset in the middle of playback
    sb_en = 1'b0;
    play_en = 1'b0;
    tick();
    capture(8'h60, 1'b0);
    play_en = 1'b1;
    repeat (5) tick();
    check("pre_rst_valid", 32'(internal_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_bit", 32'(internal_bit), 32'h0);
    check("arst_valid", 32'(internal_valid), 32'h0);
    check("arst_fill", 32'(fill_level), 32'h0);
    check("arst_state", 32'(wr_state), 32'h0);
    check("arst_ovf", 32'(overflow), 32'h0);
    check("arst_done", 32'(play_done), 32'h0);
    tick();
    rst = 1'b0;
    play_en = 1'b0;
    tick();
    check("post_rst_state", 32'(wr_state), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
